// File: rtl/lc3b_types.sv
// Shared types for the L1/L2 memory path: line, address, select and owner enum.
package lc3b_types;

    localparam int unsigned LINE_ADDR_W = 12;
    localparam int unsigned LINE_W      = 128;
    localparam int unsigned LINE_SEL_W  = LINE_W / 8;

    typedef logic [LINE_W-1:0]      lc3b_line;
    typedef logic [LINE_ADDR_W-1:0] lc3b_line_addr;
    typedef logic [LINE_SEL_W-1:0]  lc3b_sel;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with the last-served owner register.
module rr_arbiter2
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       winner,
    output logic [1:0] grant_c
);

    arb_owner_t last_grant;

    // Remember who completed most recently; decides ties on the next contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ICACHE;
        end else if (update) begin
            last_grant <= arb_owner_t'(winner);
        end
    end

    // One-hot grant (bit 0 icache, bit 1 dcache); a tie goes to whoever was not served last
    always_comb begin
        grant_c = 2'b00;
        if (req == 2'b11) begin
            grant_c = (last_grant == ICACHE) ? 2'b10 : 2'b01;
        end else begin
            grant_c = req;
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Serializes icache/dcache line requests onto the single wishbone port toward L2.
module l1_l2_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = LINE_ADDR_W,
    parameter int unsigned DATA_W = LINE_W,
    parameter int unsigned SEL_W  = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              icache_CYC,
    input  logic              icache_STB,
    input  logic              icache_WE,
    input  logic [ADDR_W-1:0] icache_ADR,
    input  logic [SEL_W-1:0]  icache_SEL,
    input  logic [DATA_W-1:0] icache_DAT_M,
    output logic [DATA_W-1:0] icache_DAT_S,
    output logic              icache_ACK,
    output logic              icache_RTY,

    input  logic              dcache_CYC,
    input  logic              dcache_STB,
    input  logic              dcache_WE,
    input  logic [ADDR_W-1:0] dcache_ADR,
    input  logic [SEL_W-1:0]  dcache_SEL,
    input  logic [DATA_W-1:0] dcache_DAT_M,
    output logic [DATA_W-1:0] dcache_DAT_S,
    output logic              dcache_ACK,
    output logic              dcache_RTY,

    output logic              l2_CYC,
    output logic              l2_STB,
    output logic              l2_WE,
    output logic [ADDR_W-1:0] l2_ADR,
    output logic [SEL_W-1:0]  l2_SEL,
    output logic [DATA_W-1:0] l2_DAT_M,
    input  logic [DATA_W-1:0] l2_DAT_S,
    input  logic              l2_ACK,
    input  logic              l2_RTY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    arb_state_t state, state_d;
    arb_owner_t owner;
    logic       rty_gap, rty_gap_d;
    logic       l2_req_d;
    logic       icache_ack_d, dcache_ack_d;
    logic       capture_req, capture_rsp, grant_update;
    logic [1:0] req, grant_c;

    // Retry is absorbed here; L1 masters only ever see a completion
    assign icache_RTY = 1'b0;
    assign dcache_RTY = 1'b0;

    assign req = {dcache_CYC & dcache_STB, icache_CYC & icache_STB};

    rr_arbiter2 u_rr (
        .clk     (CLK),
        .rst_n   (RST_N),
        .req     (req),
        .update  (grant_update),
        .winner  (owner),
        .grant_c (grant_c)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus next values of the registered L2 controls and L1 acks
    always_comb begin
        state_d      = state;
        l2_req_d     = 1'b0;
        rty_gap_d    = 1'b0;
        icache_ack_d = 1'b0;
        dcache_ack_d = 1'b0;
        capture_req  = 1'b0;
        capture_rsp  = 1'b0;
        grant_update = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_c != 2'b00) begin
                    capture_req = 1'b1;
                    l2_req_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (rty_gap) begin
                    l2_req_d = 1'b1;
                end else if (l2_ACK) begin
                    capture_rsp  = 1'b1;
                    grant_update = 1'b1;
                    icache_ack_d = (owner == ICACHE);
                    dcache_ack_d = (owner == DCACHE);
                    state_d      = RESP;
                end else if (l2_RTY) begin
                    rty_gap_d = 1'b1;
                end else begin
                    l2_req_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request registers (the only source of l2 payload), response capture and output flops
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner        <= ICACHE;
            rty_gap      <= 1'b0;
            l2_CYC       <= 1'b0;
            l2_STB       <= 1'b0;
            l2_WE        <= 1'b0;
            l2_ADR       <= '0;
            l2_SEL       <= '0;
            l2_DAT_M     <= '0;
            icache_ACK   <= 1'b0;
            dcache_ACK   <= 1'b0;
            icache_DAT_S <= '0;
            dcache_DAT_S <= '0;
        end else begin
            rty_gap    <= rty_gap_d;
            l2_CYC     <= l2_req_d;
            l2_STB     <= l2_req_d;
            icache_ACK <= icache_ack_d;
            dcache_ACK <= dcache_ack_d;
            if (capture_req) begin
                if (grant_c[1]) begin
                    owner    <= DCACHE;
                    l2_WE    <= dcache_WE;
                    l2_ADR   <= dcache_ADR;
                    l2_SEL   <= dcache_SEL;
                    l2_DAT_M <= dcache_DAT_M;
                end else begin
                    owner    <= ICACHE;
                    l2_WE    <= icache_WE;
                    l2_ADR   <= icache_ADR;
                    l2_SEL   <= icache_SEL;
                    l2_DAT_M <= icache_DAT_M;
                end
            end
            if (capture_rsp) begin
                if (owner == DCACHE) begin
                    dcache_DAT_S <= l2_DAT_S;
                end else begin
                    icache_DAT_S <= l2_DAT_S;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench: expected L2 transactions and L1 completions are queued as stimulus is set up.
module tb_l1_l2_arbiter;

    localparam int M_ACK  = 0;
    localparam int M_RTY  = 1;
    localparam int M_BOTH = 2;

    typedef struct {
        logic [11:0]  adr;
        logic         we;
        logic [127:0] dat;
        logic [127:0] rdata;
        int           lat;
        int           mode;
    } l2_txn_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic         ic_cyc, ic_stb, ic_we, dc_cyc, dc_stb, dc_we;
    logic [11:0]  ic_adr, dc_adr;
    logic [15:0]  ic_sel, dc_sel;
    logic [127:0] ic_dat, dc_dat;
    logic [127:0] icache_DAT_S, dcache_DAT_S;
    logic         icache_ACK, icache_RTY, dcache_ACK, dcache_RTY;
    logic         l2_CYC, l2_STB, l2_WE;
    logic [11:0]  l2_ADR;
    logic [15:0]  l2_SEL;
    logic [127:0] l2_DAT_M, l2_DAT_S;
    logic         l2_ACK, l2_RTY;

    l1_l2_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .icache_CYC(ic_cyc), .icache_STB(ic_stb), .icache_WE(ic_we), .icache_ADR(ic_adr),
        .icache_SEL(ic_sel), .icache_DAT_M(ic_dat), .icache_DAT_S(icache_DAT_S),
        .icache_ACK(icache_ACK), .icache_RTY(icache_RTY),
        .dcache_CYC(dc_cyc), .dcache_STB(dc_stb), .dcache_WE(dc_we), .dcache_ADR(dc_adr),
        .dcache_SEL(dc_sel), .dcache_DAT_M(dc_dat), .dcache_DAT_S(dcache_DAT_S),
        .dcache_ACK(dcache_ACK), .dcache_RTY(dcache_RTY),
        .l2_CYC(l2_CYC), .l2_STB(l2_STB), .l2_WE(l2_WE), .l2_ADR(l2_ADR), .l2_SEL(l2_SEL),
        .l2_DAT_M(l2_DAT_M), .l2_DAT_S(l2_DAT_S), .l2_ACK(l2_ACK), .l2_RTY(l2_RTY)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int l2_ack_cyc = 0;
    int ic_acks, dc_acks, ic_ack_at, dc_ack_at, ic_left, dc_left;
    bit rty_seen, l2_mute;
    bit ic_ack_prev = 1'b0;
    bit dc_ack_prev = 1'b0;

    l2_txn_t      q_l2[$];
    logic [127:0] q_ick[$];
    logic [127:0] q_dck[$];

    always @(posedge CLK) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, expv, cyc_n);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [11:0] a);
        logic [15:0] w;
        w = {4'hA, a};
        return {8{w}};
    endfunction

    task automatic push_l2(input logic [11:0] adr, input logic we, input logic [127:0] dat,
                           input logic [127:0] rdata, input int lat, input int mode);
        l2_txn_t t;
        t.adr = adr; t.we = we; t.dat = dat; t.rdata = rdata; t.lat = lat; t.mode = mode;
        q_l2.push_back(t);
    endtask

    task automatic start_ic(input logic [11:0] adr, input logic we, input logic [127:0] dat, input int n);
        ic_adr = adr; ic_we = we; ic_sel = 16'hFFFF; ic_dat = dat; ic_left = n;
        ic_cyc = 1'b1; ic_stb = 1'b1;
    endtask

    task automatic start_dc(input logic [11:0] adr, input logic we, input logic [127:0] dat, input int n);
        dc_adr = adr; dc_we = we; dc_sel = 16'hFFFF; dc_dat = dat; dc_left = n;
        dc_cyc = 1'b1; dc_stb = 1'b1;
    endtask

    task automatic clear_counts();
        ic_acks = 0; dc_acks = 0; ic_ack_at = 0; dc_ack_at = 0; rty_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #3;
        RST_N = 1'b0;
        @(posedge CLK); #3;
        RST_N = 1'b1;
        clear_counts();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((q_l2.size() != 0 || q_ick.size() != 0 || q_dck.size() != 0) && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_timeout"}, 128'(n >= budget), 128'(0));
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // L2 model: checks each issued request against the queue and answers per its mode
    initial begin : l2_model
        l2_txn_t t;
        bit want_reissue;
        want_reissue = 1'b0;
        l2_ACK = 1'b0; l2_RTY = 1'b0; l2_DAT_S = '0;
        forever begin
            @(posedge CLK); #1;
            if (want_reissue) begin
                chk("l2_reissue_after_gap", 128'(l2_STB), 128'(1));
                want_reissue = 1'b0;
            end
            if (l2_STB && !l2_mute) begin
                if (q_l2.size() == 0) begin
                    chk("l2_unexpected_req", 128'(1), 128'(0));
                end else begin
                    t = q_l2.pop_front();
                    chk("l2_cyc", 128'(l2_CYC), 128'(1));
                    chk("l2_adr", 128'(l2_ADR), 128'(t.adr));
                    chk("l2_we", 128'(l2_WE), 128'(t.we));
                    chk("l2_sel", 128'(l2_SEL), 128'(16'hFFFF));
                    chk("l2_dat_m", l2_DAT_M, t.dat);
                    repeat (t.lat) begin @(posedge CLK); #1; end
                    l2_DAT_S = t.rdata;
                    l2_ACK   = (t.mode != M_RTY);
                    l2_RTY   = (t.mode != M_ACK);
                    if (l2_ACK) l2_ack_cyc = cyc_n;
                    @(posedge CLK); #1;
                    l2_ACK = 1'b0; l2_RTY = 1'b0;
                    chk("l2_stb_drop", 128'(l2_STB), 128'(0));
                    if (t.mode == M_RTY) want_reissue = 1'b1;
                end
            end
        end
    end

    // L1 side: score completions, then let the master move on or release the bus
    initial begin : l1_mon
        logic [127:0] ev;
        forever begin
            @(posedge CLK); #1;
            if (icache_RTY || dcache_RTY) rty_seen = 1'b1;
            if (icache_ACK) begin
                chk("ic_ack_latency", 128'(cyc_n - l2_ack_cyc), 128'(1));
                chk("ic_ack_single", 128'(ic_ack_prev), 128'(0));
                if (q_ick.size() == 0) chk("ic_ack_unexpected", 128'(1), 128'(0));
                else begin ev = q_ick.pop_front(); chk("ic_dat_s", icache_DAT_S, ev); end
                ic_acks++; ic_ack_at = cyc_n; ic_left--;
                if (ic_left > 0) ic_adr = ic_adr + 12'd1;
                else begin ic_cyc = 1'b0; ic_stb = 1'b0; end
            end
            if (dcache_ACK) begin
                chk("dc_ack_latency", 128'(cyc_n - l2_ack_cyc), 128'(1));
                chk("dc_ack_single", 128'(dc_ack_prev), 128'(0));
                if (q_dck.size() == 0) chk("dc_ack_unexpected", 128'(1), 128'(0));
                else begin ev = q_dck.pop_front(); chk("dc_dat_s", dcache_DAT_S, ev); end
                dc_acks++; dc_ack_at = cyc_n; dc_left--;
                if (dc_left > 0) dc_adr = dc_adr + 12'd1;
                else begin dc_cyc = 1'b0; dc_stb = 1'b0; end
            end
            ic_ack_prev = icache_ACK;
            dc_ack_prev = dcache_ACK;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [127:0] d1;
        d1 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        RST_N = 1'b0; l2_mute = 1'b0;
        ic_cyc = 0; ic_stb = 0; ic_we = 0; ic_adr = '0; ic_sel = '0; ic_dat = '0; ic_left = 0;
        dc_cyc = 0; dc_stb = 0; dc_we = 0; dc_adr = '0; dc_sel = '0; dc_dat = '0; dc_left = 0;
        clear_counts();
        do_reset();

        // Reset values
        #1;
        chk("rst_l2_cyc", 128'(l2_CYC), 128'(0));
        chk("rst_l2_stb", 128'(l2_STB), 128'(0));
        chk("rst_l2_we", 128'(l2_WE), 128'(0));
        chk("rst_l2_adr", 128'(l2_ADR), 128'(0));
        chk("rst_l2_sel", 128'(l2_SEL), 128'(0));
        chk("rst_l2_dat_m", l2_DAT_M, 128'(0));
        chk("rst_ic_dat_s", icache_DAT_S, 128'(0));
        chk("rst_dc_dat_s", dcache_DAT_S, 128'(0));
        chk("rst_acks", 128'({icache_ACK, dcache_ACK}), 128'(0));
        chk("rst_rtys", 128'({icache_RTY, dcache_RTY}), 128'(0));

        // Lone icache read, L2 answers two cycles after the request appears
        push_l2(12'h0A3, 1'b0, 128'(0), d1, 2, M_ACK);
        q_ick.push_back(d1);
        @(posedge CLK); #1;
        start_ic(12'h0A3, 1'b0, 128'(0), 1);
        @(posedge CLK); #1;
        chk("t1_stb_next_cycle", 128'(l2_STB), 128'(1));
        wait_done("t1", 50);
        chk("t1_ic_acks", 128'(ic_acks), 128'(1));
        chk("t1_dc_acks", 128'(dc_acks), 128'(0));

        // Same-cycle requests after reset: dcache write goes first
        do_reset();
        push_l2(12'h020, 1'b1, 128'h1234, line_of(12'h020), 0, M_ACK);
        push_l2(12'h010, 1'b0, 128'(0), line_of(12'h010), 1, M_ACK);
        q_dck.push_back(line_of(12'h020));
        q_ick.push_back(line_of(12'h010));
        start_ic(12'h010, 1'b0, 128'(0), 1);
        start_dc(12'h020, 1'b1, 128'h1234, 1);
        wait_done("t2", 60);
        chk("t2_dc_before_ic", 128'(dc_ack_at < ic_ack_at), 128'(1));
        chk("t2_ack_counts", 128'({ic_acks[7:0], dc_acks[7:0]}), 128'(16'h0101));

        // Continuous contention: strict D,I alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_l2(12'h200 + 12'(i), 1'b0, 128'(0), line_of(12'h200 + 12'(i)), i, M_ACK);
            push_l2(12'h100 + 12'(i), 1'b0, 128'(0), line_of(12'h100 + 12'(i)), 2 - i, M_ACK);
            q_dck.push_back(line_of(12'h200 + 12'(i)));
            q_ick.push_back(line_of(12'h100 + 12'(i)));
        end
        start_ic(12'h100, 1'b0, 128'(0), 3);
        start_dc(12'h200, 1'b0, 128'(0), 3);
        wait_done("t3", 200);
        chk("t3_ic_acks", 128'(ic_acks), 128'(3));
        chk("t3_dc_acks", 128'(dc_acks), 128'(3));

        // One L2 retry on a dcache read
        do_reset();
        push_l2(12'h3FF, 1'b0, 128'(0), 128'(0), 1, M_RTY);
        push_l2(12'h3FF, 1'b0, 128'(0), line_of(12'h3FF), 0, M_ACK);
        q_dck.push_back(line_of(12'h3FF));
        start_dc(12'h3FF, 1'b0, 128'(0), 1);
        wait_done("t4", 60);
        chk("t4_dc_acks", 128'(dc_acks), 128'(1));
        chk("t4_ic_acks", 128'(ic_acks), 128'(0));
        chk("t4_no_l1_rty", 128'(rty_seen), 128'(0));

        // Reset while a request is on the L2 port
        do_reset();
        l2_mute = 1'b1;
        start_ic(12'h055, 1'b0, 128'(0), 1);
        @(posedge CLK); #1;
        chk("t5_issuing", 128'(l2_STB), 128'(1));
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        chk("t5_async_cyc_stb", 128'({l2_CYC, l2_STB}), 128'(0));
        chk("t5_async_adr", 128'(l2_ADR), 128'(0));
        start_dc(12'h066, 1'b1, 128'hABC, 1);
        push_l2(12'h066, 1'b1, 128'hABC, line_of(12'h066), 1, M_ACK);
        push_l2(12'h055, 1'b0, 128'(0), line_of(12'h055), 0, M_ACK);
        q_dck.push_back(line_of(12'h066));
        q_ick.push_back(line_of(12'h055));
        l2_mute = 1'b0;
        #2;
        RST_N = 1'b1;
        wait_done("t5", 60);
        chk("t5_dc_before_ic", 128'(dc_ack_at < ic_ack_at), 128'(1));
        chk("t5_ack_counts", 128'({ic_acks[7:0], dc_acks[7:0]}), 128'(16'h0101));

        // ACK and RTY together count as completion
        do_reset();
        push_l2(12'h077, 1'b0, 128'(0), line_of(12'h077), 1, M_BOTH);
        q_ick.push_back(line_of(12'h077));
        start_ic(12'h077, 1'b0, 128'(0), 1);
        wait_done("t6", 50);
        chk("t6_no_reissue", 128'(l2_STB), 128'(0));
        chk("t6_ic_acks", 128'(ic_acks), 128'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Arbitration stage between the split L1 caches (icache, dcache) and the unified L2 cache.
- Accepts line-granularity wishbone requests from both L1 miss ports and serializes them onto a single wishbone master port toward L2.
- Uses registered request/response buffering and round-robin fairness.
- Sits directly upstream of l2cache and directly downstream of the two L1 cache memory-side ports.

Parameters:
- ADDR_W, 12, line address width (word address bits above line offset).
- DATA_W, 128, line width in bits.
- SEL_W, DATA_W/8, byte-select width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- icache_CYC, icache_STB, icache_WE  in  1  icache request controls.
- icache_ADR  in  ADDR_W  icache line address.
- icache_SEL  in  SEL_W  icache byte selects.
- icache_DAT_M  in  DATA_W  icache write data.
- icache_DAT_S  out  DATA_W  read data returned to icache.
- icache_ACK, icache_RTY  out  1  completion / retry to icache.
- dcache_*  same set, same widths and directions, for dcache.
- l2_CYC, l2_STB, l2_WE  out  1  request controls toward L2.
- l2_ADR  out  ADDR_W  line address to L2.
- l2_SEL  out  SEL_W  byte selects to L2.
- l2_DAT_M  out  DATA_W  write data to L2.
- l2_DAT_S  in  DATA_W  read data from L2.
- l2_ACK, l2_RTY  in  1  L2 completion / retry.

Behaviour:
- Clocking and reset
  - All state is on CLK rising edge. RST_N low asynchronously clears all state.
  - Reset values: all l2_* controls 0, l2_ADR/SEL/DAT_M 0, both DAT_S 0, all ACK/RTY 0, last_grant = ICACHE, state = IDLE.
- Request definition: a master requests when CYC&STB. Masters hold ADR/WE/SEL/DAT stable until they see ACK (classic wishbone).
- State machine: IDLE, ISSUE, RESP.
  - IDLE:
    - No request: stay.
    - One request: grant it.
    - Both request: grant the master not equal to last_grant.
    - On grant: capture ADR/WE/SEL/DAT_M into request registers, record winner, go to ISSUE.
  - ISSUE:
    - l2_CYC=l2_STB=1, driven only from request registers.
    - l2_ACK: capture l2_DAT_S into the winner's DAT_S register, set last_grant=winner, go to RESP.
    - l2_RTY (without ACK): drop l2_CYC/STB for exactly one cycle, then reissue the same registered request. Never forward RTY to L1.
    - ACK and RTY together: treat as ACK.
  - RESP:
    - Winner's ACK=1 for exactly one cycle. Winner's DAT_S holds the captured line and stays held until that master's next completion.
    - Return to IDLE.
    - The loser's pending request is evaluated in IDLE on the following cycle.
- Latency
  - Request seen in IDLE at cycle N: l2_STB at N+1. L2 ACK at cycle M: L1 ACK at M+1.
  - Minimum round trip: 3 cycles plus L2 latency. No back-to-back ACK to the same master.
- Masters
  - icache_RTY and dcache_RTY are tied 0. They exist only for interface completeness.
  - Loser sees no ACK and no RTY. It simply stalls.
- Faults and mid-operation events
  - Master deasserts CYC during ISSUE (protocol violation): the transaction still completes to L2 and the ACK is still pulsed. No abort.
  - Reset mid-ISSUE: L2 request is dropped immediately. L2 must tolerate CYC falling.
- Fairness: strict alternation under continuous contention, so no master waits more than one foreign transaction.

Decomposition:
- lc3b_types gets: lc3b_line (DATA_W vector), lc3b_line_addr (ADDR_W), lc3b_sel (SEL_W), and enum arb_owner_t {ICACHE, DCACHE}.
- Arbiter state enum stays local to the module.
- One natural sub-module: rr_arbiter2. It is combinational grant logic plus the last_grant register: inputs req[1:0] and update strobe, output one-hot grant.

Test Plan:
- Lone icache read at ADR=12'h0A3, L2 ACKs after 2 cycles with data 128'hDEAD..BEEF: l2_STB rises 1 cycle after request; icache_ACK pulses 1 cycle after l2_ACK with icache_DAT_S=DEAD..BEEF; dcache_ACK stays 0.
- Same-cycle requests, reset state: icache ADR=12'h010 read, dcache ADR=12'h020 write SEL=16'hFFFF DAT=128'h1234: dcache issued first (last_grant=ICACHE), l2_WE=1; then icache issued; two L1 ACKs in that order.
- Continuous contention for 6 transactions: L2 order alternates D,I,D,I,D,I; each master gets exactly 3 ACKs.
- L2 asserts RTY once on a dcache read ADR=12'h3FF: l2_STB low exactly one cycle, reissued with identical ADR/WE/SEL; dcache_RTY never 1; single dcache_ACK after the final l2_ACK.
- RST_N pulled low during ISSUE: all outputs 0 asynchronously; after release, state IDLE and last_grant=ICACHE; a pending request is re-granted normally.
- Simultaneous l2_ACK and l2_RTY: treated as completion; ACK delivered, no reissue.
